// File: rtl/lane_pack_pkg.sv
// Shared widths, FSM state type and frame-slot helper for lane_pack_scheduler.
// The LANE_PACK_PAD_CFG_EN build uses this same package unchanged.
package lane_pack_pkg;

  localparam int unsigned FIELD_W    = 5;
  localparam int unsigned NUM_FIELDS = 6;
  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned FRAME_W    = 32;
  localparam int unsigned NUM_BYTES  = 4;
  localparam int unsigned PAD_W      = 2;
  localparam int unsigned SLOT_W     = $clog2(NUM_FIELDS);
  localparam int unsigned BCNT_W     = $clog2(NUM_BYTES);

  localparam logic [PAD_W-1:0] PAD = 2'b11;

  typedef enum logic {
    COLLECT = 1'b0,
    EMIT    = 1'b1
  } state_e;

  // Left-shift that places a field in its slot; slot 0 sits at the frame MSBs.
  function automatic int unsigned slot_shift(input logic [SLOT_W-1:0] slot);
    return FRAME_W - FIELD_W * (32'(slot) + 1);
  endfunction

endpackage

// File: rtl/lane_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first active request at or above
// rr_ptr_i, wrapping around; no grant when enable_i is low.
module lane_rr_arbiter #(
  parameter int unsigned NUM_FIELDS = 6
) (
  input  logic [NUM_FIELDS-1:0]         req_i,
  input  logic [$clog2(NUM_FIELDS)-1:0] rr_ptr_i,
  input  logic                          enable_i,
  output logic [NUM_FIELDS-1:0]         gnt_o
);

  localparam int unsigned PtrW = $clog2(NUM_FIELDS);

  logic [PtrW-1:0] idx;
  logic            found;

  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned k = 0; k < NUM_FIELDS; k++) begin
      idx = PtrW'((32'(rr_ptr_i) + k) % NUM_FIELDS);
      if (enable_i && !found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/lane_pack_scheduler.sv
// Packs six round-robin-arbitrated 5-bit fields plus 2 pad bits into a 32-bit frame
// and streams it MSB-first as four bytes. Optional macro: LANE_PACK_PAD_CFG_EN (pad_cfg port).
module lane_pack_scheduler
  import lane_pack_pkg::*;
(
  input  logic                          clk,
  input  logic                          areset,
  input  logic [NUM_FIELDS-1:0]         req,
  input  logic [NUM_FIELDS*FIELD_W-1:0] req_data,
`ifdef LANE_PACK_PAD_CFG_EN
  input  logic [PAD_W-1:0]              pad_cfg,
`endif
  output logic [NUM_FIELDS-1:0]         gnt,
  output logic [BYTE_W-1:0]             out_byte,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          out_last,
  output logic                          busy
);

  if (FRAME_W != FIELD_W * NUM_FIELDS + PAD_W || FRAME_W != NUM_BYTES * BYTE_W) begin : g_cfg_check
    $error("lane_pack_scheduler: field, pad and byte widths do not tile the frame");
  end

  state_e              state_q, state_d;
  logic [SLOT_W-1:0]   slot_cnt_q, slot_cnt_d;
  logic [SLOT_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [BCNT_W-1:0]   byte_cnt_q, byte_cnt_d;
  logic [FRAME_W-1:0]  frame_q, frame_d;

  logic                arb_en;
  logic                gnt_any;
  logic [SLOT_W-1:0]   gnt_idx;
  logic [FIELD_W-1:0]  gnt_field;
  logic [PAD_W-1:0]    pad_val;
  logic [FRAME_W-1:0]  field_mask;
  logic [FRAME_W-1:0]  field_ins;

  assign arb_en = (state_q == COLLECT);

  lane_rr_arbiter #(
    .NUM_FIELDS(NUM_FIELDS)
  ) u_arb (
    .req_i   (req),
    .rr_ptr_i(rr_ptr_q),
    .enable_i(arb_en),
    .gnt_o   (gnt)
  );

`ifdef LANE_PACK_PAD_CFG_EN
  assign pad_val = pad_cfg;
`else
  assign pad_val = PAD;
`endif

  // One-hot grant to index and the granted requester's field.
  always_comb begin
    gnt_idx   = '0;
    gnt_field = '0;
    for (int unsigned i = 0; i < NUM_FIELDS; i++) begin
      if (gnt[i]) begin
        gnt_idx   = SLOT_W'(i);
        gnt_field = req_data[i*FIELD_W +: FIELD_W];
      end
    end
  end

  assign gnt_any    = |gnt;
  assign field_mask = FRAME_W'({FIELD_W{1'b1}}) << slot_shift(slot_cnt_q);
  assign field_ins  = FRAME_W'(gnt_field) << slot_shift(slot_cnt_q);

  always_comb begin
    state_d    = state_q;
    slot_cnt_d = slot_cnt_q;
    rr_ptr_d   = rr_ptr_q;
    byte_cnt_d = byte_cnt_q;
    frame_d    = frame_q;
    unique case (state_q)
      COLLECT: begin
        if (gnt_any) begin
          frame_d  = (frame_q & ~field_mask) | field_ins;
          rr_ptr_d = (gnt_idx == SLOT_W'(NUM_FIELDS - 1)) ? '0 : gnt_idx + SLOT_W'(1);
          if (slot_cnt_q == SLOT_W'(NUM_FIELDS - 1)) begin
            frame_d    = {frame_d[FRAME_W-1:PAD_W], pad_val};
            byte_cnt_d = '0;
            state_d    = EMIT;
          end else begin
            slot_cnt_d = slot_cnt_q + SLOT_W'(1);
          end
        end
      end
      EMIT: begin
        if (out_ready) begin
          byte_cnt_d = byte_cnt_q + BCNT_W'(1);
          if (byte_cnt_q == BCNT_W'(NUM_BYTES - 1)) begin
            slot_cnt_d = '0;
            state_d    = COLLECT;
          end
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state_q    <= COLLECT;
      slot_cnt_q <= '0;
      rr_ptr_q   <= '0;
      byte_cnt_q <= '0;
      frame_q    <= '0;
    end else begin
      state_q    <= state_d;
      slot_cnt_q <= slot_cnt_d;
      rr_ptr_q   <= rr_ptr_d;
      byte_cnt_q <= byte_cnt_d;
      frame_q    <= frame_d;
    end
  end

  // Outputs decode registered state only, so reset drops out_valid without a clock.
  assign busy      = (state_q == EMIT);
  assign out_valid = busy;
  assign out_last  = busy && (byte_cnt_q == BCNT_W'(NUM_BYTES - 1));
  assign out_byte  = busy ? BYTE_W'(frame_q >> (BYTE_W * (NUM_BYTES - 1 - 32'(byte_cnt_q))))
                          : '0;

endmodule
